// File: rtl/xrvs_pkg.sv
// Shared types for the mrv1 issue scheduler.
package xrvs_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } mrv1_sched_state_e;

endpackage

// File: rtl/xrv_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module xrv_rr_arb #(
   parameter int N_P  = 8,
   parameter int IW_P = (N_P > 1) ? $clog2(N_P) : 1
) (
   input  logic [N_P-1:0]  req_i,
   input  logic [IW_P-1:0] ptr_i,
   output logic [N_P-1:0]  gnt_o,
   output logic [IW_P-1:0] idx_o,
   output logic            vld_o
);

   int                pos;
   logic [IW_P-1:0]   k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      pos   = 0;
      k     = '0;
      for (int i = 0; i < N_P; i++) begin
         pos = int'(ptr_i) + i;
         if (pos >= N_P) pos = pos - N_P;
         k = IW_P'(pos);
         if (!vld_o && req_i[k]) begin
            vld_o    = 1'b1;
            idx_o    = k;
            gnt_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mrv1_issue_sched.sv
// Multi-thread issue scheduler: round-robin grant over eligible threads,
// per-thread in-flight credit counters and a halt/drain FSM.
module mrv1_issue_sched
   import xrvs_pkg::*;
#(
   parameter int NUM_TW_P       = 8,
   parameter int NUM_FU_P       = 6,
   parameter int MAX_INFLIGHT_P = 4,
   parameter int TW_P           = (NUM_TW_P > 1) ? $clog2(NUM_TW_P) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_TW_P-1:0]          thr_vld_i,
   input  logic [NUM_TW_P-1:0]          thr_conflict_i,
   input  logic [NUM_TW_P*NUM_FU_P-1:0] thr_fu_sel_i,
   input  logic [NUM_FU_P-1:0]          exec_fu_rdy_i,
   input  logic                         retire_vld_i,
   input  logic [TW_P-1:0]              retire_tid_i,
   input  logic                         halt_req_i,
   output logic                         issue_vld_o,
   output logic [TW_P-1:0]              issue_tid_o,
   output logic [NUM_TW_P-1:0]          deq_o,
   output logic [NUM_FU_P-1:0]          exec_fu_req_o,
   output logic [NUM_TW_P-1:0]          credit_full_o,
   output logic                         halted_o
);

   localparam int              CW      = $clog2(MAX_INFLIGHT_P + 1);
   localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_INFLIGHT_P);

   mrv1_sched_state_e  state_q, state_d;
   logic               halted_q;
   logic [TW_P-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]      cnt_q [NUM_TW_P];
   logic [CW-1:0]      cnt_d [NUM_TW_P];

   logic [NUM_TW_P-1:0] elig, busy, dec, gnt;
   logic [TW_P-1:0]     gnt_idx;
   logic                gnt_vld;
   logic                run;

   assign run = (state_q == RUN);

   for (genvar gi = 0; gi < NUM_TW_P; gi++) begin : g_thr
      assign credit_full_o[gi] = (cnt_q[gi] == MAX_CNT);
      assign busy[gi]          = (cnt_q[gi] != '0);
      assign elig[gi]          = thr_vld_i[gi] & ~thr_conflict_i[gi] & ~credit_full_o[gi] & run
                               & (|(thr_fu_sel_i[gi*NUM_FU_P +: NUM_FU_P] & exec_fu_rdy_i));

      // A retire against an empty counter is dropped rather than wrapping.
      assign dec[gi]   = retire_vld_i & (retire_tid_i == TW_P'(gi)) & busy[gi];
      assign cnt_d[gi] = (gnt[gi] & ~dec[gi]) ? cnt_q[gi] + CW'(1) :
                         (dec[gi] & ~gnt[gi]) ? cnt_q[gi] - CW'(1) : cnt_q[gi];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) cnt_q[gi] <= '0;
         else       cnt_q[gi] <= cnt_d[gi];
      end
   end

   xrv_rr_arb #(
      .N_P  (NUM_TW_P),
      .IW_P (TW_P)
   ) u_arb (
      .req_i (elig),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .vld_o (gnt_vld)
   );

   assign issue_vld_o   = gnt_vld;
   assign issue_tid_o   = gnt_idx;
   assign deq_o         = gnt;
   assign exec_fu_req_o = gnt_vld ? thr_fu_sel_i[gnt_idx*NUM_FU_P +: NUM_FU_P] : '0;
   assign halted_o      = halted_q;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         rr_ptr_d = (gnt_idx == TW_P'(NUM_TW_P - 1)) ? '0 : gnt_idx + TW_P'(1);
      end
   end

   // Drain completion looks at registered counters only, so halted lags the last retire by two cycles.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (halt_req_i) state_d = DRAIN;
         DRAIN:   if (!halt_req_i) state_d = RUN;
                  else if (~|busy) state_d = HALTED;
         HALTED:  if (!halt_req_i) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_d == HALTED);
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_mrv1_issue_sched.sv
// Directed vector bench for mrv1_issue_sched (default parameters).
module tb_mrv1_issue_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  thr_vld = '0;
   logic [7:0]  thr_conflict = '0;
   logic [47:0] thr_fu_sel;
   logic [5:0]  fu_rdy = '0;
   logic        ret_vld = 1'b0;
   logic [2:0]  ret_tid = '0;
   logic        halt_req = 1'b0;
   logic        issue_vld;
   logic [2:0]  issue_tid;
   logic [7:0]  deq;
   logic [5:0]  fu_req;
   logic [7:0]  credit_full;
   logic        halted;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [7:0] vld;
      logic [7:0] conf;
      logic [5:0] rdy;
      logic [3:0] ret;   // bit 3 = retire valid, [2:0] = tid
      logic       halt;
      logic       e_iv;
      logic [2:0] e_tid;
      logic [7:0] e_deq;
      logic [5:0] e_fu;
      logic [7:0] e_cf;
      logic       e_halted;
   } vec_t;

   vec_t seq[$];

   always #5 clk = ~clk;

   mrv1_issue_sched dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .thr_vld_i      (thr_vld),
      .thr_conflict_i (thr_conflict),
      .thr_fu_sel_i   (thr_fu_sel),
      .exec_fu_rdy_i  (fu_rdy),
      .retire_vld_i   (ret_vld),
      .retire_tid_i   (ret_tid),
      .halt_req_i     (halt_req),
      .issue_vld_o    (issue_vld),
      .issue_tid_o    (issue_tid),
      .deq_o          (deq),
      .exec_fu_req_o  (fu_req),
      .credit_full_o  (credit_full),
      .halted_o       (halted)
   );

   // Thread t targets FU (t mod 6): t0->000001, t2->000100, t5->100000, t7->000010.
   initial begin
      for (int t = 0; t < 8; t++) thr_fu_sel[t*6 +: 6] = 6'(1 << (t % 6));
   end

   function automatic vec_t mk(logic [7:0] vld, logic [7:0] conf, logic [5:0] rdy, logic [3:0] ret,
                               logic halt, logic iv, logic [2:0] tid, logic [7:0] dq,
                               logic [5:0] fu, logic [7:0] cf, logic h);
      vec_t v;
      v.vld = vld; v.conf = conf; v.rdy = rdy; v.ret = ret; v.halt = halt;
      v.e_iv = iv; v.e_tid = tid; v.e_deq = dq; v.e_fu = fu; v.e_cf = cf; v.e_halted = h;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic apply(input vec_t v);
      thr_vld      = v.vld;
      thr_conflict = v.conf;
      fu_rdy       = v.rdy;
      ret_vld      = v.ret[3];
      ret_tid      = v.ret[2:0];
      halt_req     = v.halt;
   endtask

   task automatic check_row(input string tag, input int i, input vec_t v);
      $display("%s[%0d] vld=%h conf=%h rdy=%b ret=%h halt=%0b -> iv=%0b tid=%0d deq=%h fu=%b cf=%h halted=%0b",
               tag, i, v.vld, v.conf, v.rdy, v.ret, v.halt, issue_vld, issue_tid, deq, fu_req, credit_full, halted);
      chk($sformatf("%s[%0d] issue_vld", tag, i),   32'(issue_vld),   32'(v.e_iv));
      chk($sformatf("%s[%0d] issue_tid", tag, i),   32'(issue_tid),   32'(v.e_tid));
      chk($sformatf("%s[%0d] deq", tag, i),         32'(deq),         32'(v.e_deq));
      chk($sformatf("%s[%0d] exec_fu_req", tag, i), 32'(fu_req),      32'(v.e_fu));
      chk($sformatf("%s[%0d] credit_full", tag, i), 32'(credit_full), 32'(v.e_cf));
      chk($sformatf("%s[%0d] halted", tag, i),      32'(halted),      32'(v.e_halted));
   endtask

   task automatic run_seq(input string tag);
      for (int i = 0; i < seq.size(); i++) begin
         @(posedge clk);
         #1;
         apply(seq[i]);
         @(negedge clk);
         check_row(tag, i, seq[i]);
      end
      seq.delete();
   endtask

   localparam logic [5:0] ALL = 6'h3F;
   localparam logic [7:0] Z8  = 8'h00;
   localparam logic [3:0] NR  = 4'h0;

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Basic round robin, wrap, FU readiness, conflicts and credit limit.
      seq.push_back(mk(Z8,    Z8,    ALL,   NR,    1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(8'hFF, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd0, 8'h01, 6'h01, Z8,    1'b0));
      seq.push_back(mk(8'hFF, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd1, 8'h02, 6'h02, Z8,    1'b0));
      seq.push_back(mk(8'hFF, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd2, 8'h04, 6'h04, Z8,    1'b0));
      seq.push_back(mk(8'hFF, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd3, 8'h08, 6'h08, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'h8,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'h9,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'hA,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'hB,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(8'h80, Z8,    ALL,   4'hF,  1'b0, 1'b1, 3'd7, 8'h80, 6'h02, Z8,    1'b0));
      seq.push_back(mk(8'h81, Z8,    ALL,   4'hF,  1'b0, 1'b1, 3'd0, 8'h01, 6'h01, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'h8,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(8'h04, Z8,    6'h3B, NR,    1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(8'h04, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd2, 8'h04, 6'h04, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'hA,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      seq.push_back(mk(8'h06, 8'h02, ALL,   NR,    1'b0, 1'b1, 3'd2, 8'h04, 6'h04, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'hA,  1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8,    1'b0));
      for (int k = 0; k < 4; k++)
         seq.push_back(mk(8'h02, Z8, ALL, NR, 1'b0, 1'b1, 3'd1, 8'h02, 6'h02, Z8, 1'b0));
      seq.push_back(mk(8'h02, Z8,    ALL,   NR,    1'b0, 1'b0, 3'd0, Z8,    6'h00, 8'h02, 1'b0));
      seq.push_back(mk(8'h02, Z8,    ALL,   4'h9,  1'b0, 1'b0, 3'd0, Z8,    6'h00, 8'h02, 1'b0));
      seq.push_back(mk(8'h02, Z8,    ALL,   4'h9,  1'b0, 1'b1, 3'd1, 8'h02, 6'h02, Z8,    1'b0));
      seq.push_back(mk(8'h02, Z8,    ALL,   NR,    1'b0, 1'b1, 3'd1, 8'h02, 6'h02, Z8,    1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   NR,    1'b0, 1'b0, 3'd0, Z8,    6'h00, 8'h02, 1'b0));
      seq.push_back(mk(Z8,    Z8,    ALL,   4'h9,  1'b0, 1'b0, 3'd0, Z8,    6'h00, 8'h02, 1'b0));
      for (int k = 0; k < 3; k++)
         seq.push_back(mk(Z8, Z8, ALL, 4'h9, 1'b0, 1'b0, 3'd0, Z8, 6'h00, Z8, 1'b0));
      run_seq("vec");

      // Halt request: grant in the rising cycle, drain two retires, halted two cycles later, resume.
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b0, 1'b1, 3'd3, 8'h08, 6'h08, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b1, 1'b1, 3'd3, 8'h08, 6'h08, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b1, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, 4'hB, 1'b1, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, 4'hB, 1'b1, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b1, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b0));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b1, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b1));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b1));
      seq.push_back(mk(8'h08, Z8, ALL, NR,   1'b0, 1'b1, 3'd3, 8'h08, 6'h08, Z8, 1'b0));
      seq.push_back(mk(Z8,    Z8, ALL, 4'hB, 1'b0, 1'b0, 3'd0, Z8,    6'h00, Z8, 1'b0));
      run_seq("halt");

      // Build cnt[5]=3, enter DRAIN, then reset asynchronously mid-cycle.
      for (int k = 0; k < 3; k++)
         seq.push_back(mk(8'h20, Z8, ALL, NR, 1'b0, 1'b1, 3'd5, 8'h20, 6'h20, Z8, 1'b0));
      seq.push_back(mk(Z8,    Z8, ALL, NR, 1'b1, 1'b0, 3'd0, Z8, 6'h00, Z8, 1'b0));
      seq.push_back(mk(8'h20, Z8, ALL, NR, 1'b1, 1'b0, 3'd0, Z8, 6'h00, Z8, 1'b0));
      run_seq("drain");

      #2 rst = 1'b1;
      #1;
      $display("rst_async iv=%0b tid=%0d deq=%h fu=%b cf=%h halted=%0b",
               issue_vld, issue_tid, deq, fu_req, credit_full, halted);
      chk("rst_async issue_vld",   32'(issue_vld),   32'd1);
      chk("rst_async issue_tid",   32'(issue_tid),   32'd5);
      chk("rst_async exec_fu_req", 32'(fu_req),      32'h20);
      chk("rst_async credit_full", 32'(credit_full), 32'h0);
      chk("rst_async halted",      32'(halted),      32'd0);
      thr_vld  = '0;
      halt_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Retire to an empty thread is ignored: exactly four grants fill thread 5.
      seq.push_back(mk(Z8, Z8, ALL, 4'hD, 1'b0, 1'b0, 3'd0, Z8, 6'h00, Z8, 1'b0));
      for (int k = 0; k < 4; k++)
         seq.push_back(mk(8'h20, Z8, ALL, NR, 1'b0, 1'b1, 3'd5, 8'h20, 6'h20, Z8, 1'b0));
      seq.push_back(mk(8'h20, Z8, ALL, NR, 1'b0, 1'b0, 3'd0, Z8, 6'h00, 8'h20, 1'b0));
      run_seq("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
